// File: rtl/fbs_if.sv
// fbs_if: bundle between the control unit / F-register file and the fbs
// snapshot stack.
//
// Signal summary:
//   backup      control -> fbs   push request (sampled every rising clk)
//   restore     control -> fbs   pop request  (sampled every rising clk)
//   dataIn      control -> fbs   register-file image to save
//   dataOut     fbs -> control   last pushed image, or image just popped
//   restoreOut  fbs -> control   one-cycle pulse after each successful pop
//   fcc         fbs -> control   current stack depth (frame call count)
//
// Handshake: there is no ready/stall path. A request that is high at a
// rising edge is acted on at that edge or dropped for good (push when full,
// pop when empty). backup has priority over restore when both are high.
// restore is level-sensitive, so holding it high pops once per cycle.
interface fbs_if #(
  parameter int WIDTH = 256,
  parameter int CW    = 16
);
  logic             backup;
  logic             restore;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] dataOut;
  logic             restoreOut;
  logic [CW-1:0]    fcc;

  // Control unit side.
  modport master (
    output backup, restore, dataIn,
    input  dataOut, restoreOut, fcc
  );

  // Snapshot stack side.
  modport slave (
    input  backup, restore, dataIn,
    output dataOut, restoreOut, fcc
  );
endinterface

// File: rtl/fbs.sv
// fbs: F-register backup system. A LIFO stack of full register-file
// snapshots, pushed on procedure call and popped on return.
//
// Ports:
//   clk    system clock, all state changes on its rising edge
//   rst_n  asynchronous active-low reset; clears fcc, dataOut, restoreOut
//   bus    fbs_if.slave: backup/restore/dataIn in, dataOut/restoreOut/fcc out
//
// Parameters:
//   WIDTH  bits per snapshot
//   DEPTH  number of snapshot entries
//   CW     width of the depth counter (must hold 0..DEPTH)
module fbs #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 16,
  parameter int CW    = 16
) (
  input logic  clk,
  input logic  rst_n,
  fbs_if.slave bus
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  // Snapshot storage. Not reset: fcc alone decides which entries are live.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    fcc_q, fcc_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             restore_out_q, restore_out_d;

  logic             do_push;
  logic             do_pop;
  logic [AW-1:0]    push_addr;
  logic [AW-1:0]    pop_addr;

  // Request decode. Push wins over pop; both saturate at the stack limits.
  always_comb begin
    do_push   = bus.backup && (fcc_q < DEPTH_C);
    do_pop    = !bus.backup && bus.restore && (fcc_q != '0);
    push_addr = AW'(fcc_q);
    pop_addr  = AW'(fcc_q - ONE_C);
  end

  always_comb begin
    fcc_d         = fcc_q;
    data_out_d    = data_out_q;
    restore_out_d = 1'b0;
    if (do_push) begin
      fcc_d      = fcc_q + ONE_C;
      data_out_d = bus.dataIn;
    end else if (do_pop) begin
      fcc_d         = fcc_q - ONE_C;
      data_out_d    = mem[pop_addr];
      restore_out_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcc_q         <= '0;
      data_out_q    <= '0;
      restore_out_q <= 1'b0;
    end else begin
      fcc_q         <= fcc_d;
      data_out_q    <= data_out_d;
      restore_out_q <= restore_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[push_addr] <= bus.dataIn;
    end
  end

  assign bus.dataOut    = data_out_q;
  assign bus.restoreOut = restore_out_q;
  assign bus.fcc        = fcc_q;

endmodule

// File: tb/tb_fbs.sv
module tb_fbs;
  localparam int W     = 256;
  localparam int DEPTH = 16;
  localparam int CW    = 16;

  logic clk;
  logic rst_n;

  fbs_if #(.WIDTH(W), .CW(CW)) bus ();

  fbs #(.WIDTH(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue used as the stack
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_data;
  logic          exp_rest;
  logic [CW-1:0] exp_fcc;

  int tests;
  int fails;

  task automatic chk_data(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dataOut: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_small(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk_data(tag, bus.dataOut, exp_data);
    chk_small({tag, " fcc"}, bus.fcc, exp_fcc);
    chk_small({tag, " restoreOut"}, CW'(bus.restoreOut), CW'(exp_rest));
  endtask

  // Model of one rising edge with the given requests
  task automatic model_edge(input logic b, input logic r, input logic [W-1:0] d);
    exp_rest = 1'b0;
    if (b) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(d);
        exp_data = d;
      end
    end else if (r && exp_q.size() > 0) begin
      exp_data = exp_q.pop_back();
      exp_rest = 1'b1;
    end
    exp_fcc = CW'(exp_q.size());
  endtask

  // Driver: apply requests for one cycle, then check just after the edge
  task automatic step(input string tag, input logic b, input logic r, input logic [W-1:0] d);
    @(negedge clk);
    bus.backup  = b;
    bus.restore = r;
    bus.dataIn  = d;
    @(posedge clk);
    model_edge(b, r, d);
    #1;
    check_all(tag);
  endtask

  // Async reset asserted mid-cycle, checked before any clock edge
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_data = '0;
    exp_rest = 1'b0;
    exp_fcc  = '0;
    #1;
    check_all(tag);
    @(negedge clk);
    bus.backup  = 1'b0;
    bus.restore = 1'b0;
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.backup  = 1'b0;
    bus.restore = 1'b0;
    bus.dataIn  = '0;
    exp_data = '0;
    exp_rest = 1'b0;
    exp_fcc  = '0;
    repeat (2) @(negedge clk);
    check_all("reset_initial");
    rst_n = 1'b1;

    // Put something in the stack so reset has state to clear
    step("pre_reset_push", 1'b1, 1'b0, W'(32'hdead_beef));
    step("pre_reset_push", 1'b1, 1'b0, W'(32'h1234_5678));
    async_reset("reset_mid_cycle");
    step("idle_after_reset", 1'b0, 1'b1, W'(5));

    // Fill to the top
    for (int i = 0; i < DEPTH; i++) step("push16", 1'b1, 1'b0, W'(i));
    chk_small("full_depth", bus.fcc, CW'(16));

    // Overflow is ignored
    step("overflow", 1'b1, 1'b0, W'(99));
    chk_data("overflow_hold", bus.dataOut, W'(15));

    // Pop all 16, restore held high
    for (int i = DEPTH - 1; i >= 0; i--) begin
      step("pop16", 1'b0, 1'b1, '0);
      chk_data("pop16_lifo", bus.dataOut, W'(i));
    end

    // Underflow is ignored
    for (int i = 0; i < 3; i++) step("underflow", 1'b0, 1'b1, '0);

    // Simultaneous requests: push wins
    step("sim_pre", 1'b1, 1'b0, W'(3));
    step("sim_pre", 1'b1, 1'b0, W'(4));
    step("simultaneous", 1'b1, 1'b1, W'(7));
    chk_small("simultaneous_fcc", bus.fcc, CW'(3));
    step("pop_after_push", 1'b0, 1'b1, '0);
    chk_data("pop_after_push_val", bus.dataOut, W'(7));

    // Randomized traffic, alternating push-heavy and pop-heavy phases
    for (int n = 0; n < 600; n++) begin
      int sel;
      logic b, r;
      sel = $urandom_range(0, 99);
      if (((n / 40) % 2) == 0) begin
        b = (sel < 60);
        r = (sel >= 45);
      end else begin
        b = (sel < 20);
        r = (sel >= 10);
      end
      if ($urandom_range(0, 199) == 0) async_reset("rand_reset");
      else step("random", b, r, rand_word());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the bench always ends
  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
